// File: rtl/fifo_serial_tx_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter: FSM state encoding
// and default geometry.
package fifo_serial_tx_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIV   = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_FETCH   = 3'd1;
  localparam state_t S_CAPTURE = 3'd2;
  localparam state_t S_START   = 3'd3;
  localparam state_t S_DATA    = 3'd4;
  localparam state_t S_PARITY  = 3'd5;
  localparam state_t S_STOP    = 3'd6;

  // True in the states that drive a timed symbol onto the line.
  function automatic logic is_bit_state(input state_t s);
    return (s == S_START) || (s == S_DATA) || (s == S_PARITY) || (s == S_STOP);
  endfunction

endpackage

// File: rtl/fifo_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 while run is high and flags the last
// cycle of each period with tick.
module fifo_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pulls words from a FIFO read port and sends each as start, LSB-first data,
// even parity and stop symbols of DIV clocks each.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rd_rq,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       sent_count
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             parity;
  logic [IW-1:0]    bit_idx;
  logic             tick;

  fifo_bit_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .start  (state == S_CAPTURE),
    .run    (is_bit_state(state)),
    .tick   (tick)
  );

  // frame_done doubles as a one-cycle IDLE hold so consecutive frames are
  // separated by at least four idle-high cycles.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      parity     <= 1'b0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
      sent_count <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_en && !empty && !frame_done) state <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          shreg   <= rdata;
          parity  <= ^rdata;
          bit_idx <= '0;
          state   <= S_START;
        end
        S_START: begin
          if (tick) state <= S_DATA;
        end
        S_DATA: begin
          if (tick) begin
            shreg <= shreg >> 1;
            if (bit_idx == IW'(WIDTH - 1)) begin
              state <= S_PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (tick) state <= S_STOP;
        end
        S_STOP: begin
          if (tick) begin
            state      <= S_IDLE;
            frame_done <= 1'b1;
            sent_count <= sent_count + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shreg[0];
      S_PARITY: tx = parity;
      default:  tx = 1'b1;
    endcase
  end

  assign rd_rq = (state == S_FETCH);
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx with a cycle-level frame-timing model and
// hand-computed symbol sequences.
module tb_fifo_serial_tx;

  localparam int W     = 4;
  localparam int D     = 4;
  localparam int FRAME = (W + 3) * D;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         tx_en;
  logic         empty;
  logic [W-1:0] rdata;
  logic         rd_rq;
  logic         tx;
  logic         busy;
  logic         frame_done;
  logic [7:0]   sent_count;

  logic [W-1:0] mem [0:511];
  int           wr_cnt = 0;
  int           rd_cnt = 0;

  int total = 0;
  int bad   = 0;

  int           cyc       = 0;
  int           s_start   = -100000;
  int           free_at   = 0;
  int           count_exp = 0;
  int           mptr      = 0;
  logic [W-1:0] m_word    = '0;
  int           frames_seen = 0;
  int           rd_seen     = 0;

  assign empty = (wr_cnt == rd_cnt);

  fifo_serial_tx #(
    .WIDTH (W),
    .DIV   (D)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .empty      (empty),
    .rdata      (rdata),
    .rd_rq      (rd_rq),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .sent_count (sent_count)
  );

  initial forever #5 clk_in = ~clk_in;

  // Line level d cycles after the sampling cycle of a frame carrying w.
  function automatic logic exp_tx(input int d, input logic [W-1:0] w);
    int k;
    int ph;
    k = d - 3;
    if (k < 0 || k >= FRAME) return 1'b1;
    ph = k / D;
    if (ph == 0) return 1'b0;
    if (ph <= W) return w[ph-1];
    if (ph == W + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      s_start   = -100000;
      free_at   = 0;
      count_exp = 0;
    end else if (cyc >= free_at && tx_en && !empty) begin
      s_start = cyc;
      m_word  = mem[mptr];
      mptr++;
      free_at = cyc + 4 + FRAME;
    end
    cyc++;
    if (rst_n && cyc == s_start + FRAME + 3) count_exp = (count_exp + 1) % 256;
  endtask

  task automatic check_cycle();
    logic [11:0] e;
    logic [11:0] a;
    int d;
    d = cyc - s_start;
    if (!rst_n) e = {1'b1, 3'b000, 8'd0};
    else e = {exp_tx(d, m_word), (d >= 1 && d <= FRAME + 2), (d == 1),
              (d == FRAME + 3), count_exp[7:0]};
    a = {tx, busy, rd_rq, frame_done, sent_count};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL cycle %0d tx/busy/rd_rq/done/count got %b want %b", cyc, a, e);
    end
    if (frame_done === 1'b1) frames_seen++;
    if (rd_rq === 1'b1) rd_seen++;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_cycle();
    if (rst_n && rd_rq) begin
      rdata = mem[rd_cnt];
      rd_cnt++;
    end
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    mem[wr_cnt] = w;
    wr_cnt++;
  endtask

  task automatic wait_tx_low(input string name);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check({name, " start seen"}, 16'(tx), 16'd0);
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      tick();
      n++;
    end
    check({name, " frames reached"}, 16'(frames_seen >= target), 16'd1);
  endtask

  // seq bit i is the i-th symbol on the line: start, data LSB first, parity, stop.
  task automatic check_frame_lit(input string name, input logic [6:0] seq);
    wait_tx_low(name);
    if (tx === 1'b0) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("%s symbol %0d", name, i), 16'(tx), 16'(seq[i]));
        repeat (D) tick();
      end
      check({name, " frame_done"}, 16'(frame_done), 16'd1);
    end
  endtask

  int f0;
  int r0;

  initial begin
    rst_n = 1'b0;
    tx_en = 1'b0;
    rdata = '0;
    repeat (3) tick();
    check("reset outputs", {4'd0, tx, busy, rd_rq, frame_done, sent_count}, 16'h0800);
    rst_n = 1'b1;

    push(4'hA);
    tx_en = 1'b1;
    check_frame_lit("word A", 7'b1010100);
    check("A rd_rq pulses", 16'(rd_seen), 16'd1);
    check("A frames", 16'(frames_seen), 16'd1);
    check("A sent_count", 16'(sent_count), 16'd1);

    push(4'h7);
    check_frame_lit("word 7", 7'b1101110);
    push(4'h0);
    check_frame_lit("word 0", 7'b1000000);
    push(4'hF);
    check_frame_lit("word F", 7'b1011110);

    f0 = frames_seen;
    r0 = rd_seen;
    for (int i = 1; i <= 8; i++) push(4'(i));
    wait_frames("stream", f0 + 8, 8 * (FRAME + 8) + 20);
    repeat (20) tick();
    check("stream rd_rq pulses", 16'(rd_seen - r0), 16'd8);
    check("stream frames", 16'(frames_seen - f0), 16'd8);
    check("stream sent_count", 16'(sent_count), 16'd12);
    check("stream idle after", 16'(busy), 16'd0);

    tx_en = 1'b0;
    f0 = frames_seen;
    r0 = rd_seen;
    push(4'h5);
    repeat (40) tick();
    check("gated rd_rq", 16'(rd_seen - r0), 16'd0);
    check("gated line", {14'd0, tx, busy}, 16'h0002);
    tx_en = 1'b1;
    wait_tx_low("enable mid");
    repeat (6) tick();
    tx_en = 1'b0;
    push(4'h6);
    wait_frames("drop en", f0 + 1, FRAME + 20);
    repeat (40) tick();
    check("drop en frames", 16'(frames_seen - f0), 16'd1);
    check("drop en rd_rq", 16'(rd_seen - r0), 16'd1);
    check("drop en idle", 16'(busy), 16'd0);

    tx_en = 1'b1;
    wait_tx_low("pre reset");
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1 check("async reset line", {13'd0, tx, busy, rd_rq}, 16'h0004);
    repeat (2) tick();
    rst_n = 1'b1;
    push(4'h9);
    check_frame_lit("word 9 after reset", 7'b1010010);
    check("after reset sent_count", 16'(sent_count), 16'd1);

    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    f0 = frames_seen;
    r0 = rd_seen;
    for (int i = 0; i < 256; i++) push(4'(i));
    wait_frames("wrap", f0 + 256, 256 * (FRAME + 8) + 100);
    check("wrap sent_count", 16'(sent_count), 16'd0);
    check("wrap frames", 16'(frames_seen - f0), 16'd256);
    check("wrap rd_rq", 16'(rd_seen - r0), 16'd256);
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
